// File: rtl/sfifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty levels, occupancy count, flush and
// sticky error flags. Define SFIFO_PROG_FWFT_EN for first-word-fall-through reads.
module sfifo_prog #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_winc,
  input  logic                  i_rinc,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic [ADDR_WIDTH:0]   i_afull_lvl,
  input  logic [ADDR_WIDTH:0]   i_aempty_lvl,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_wfull,
  output logic                  o_wfull_almost,
  output logic                  o_rempty,
  output logic                  o_rempty_almost,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  assign o_wfull         = (count_q == DepthCnt);
  assign o_rempty        = (count_q == '0);
  assign o_wfull_almost  = (count_q >= i_afull_lvl);
  assign o_rempty_almost = (count_q <= i_aempty_lvl);
  assign o_count         = count_q;
  assign o_overflow      = ovf_q;
  assign o_underflow     = unf_q;

  always_comb begin
    // Flush swallows both requests, including their error side effects.
    wr_acc   = i_winc & ~o_wfull & ~i_flush;
    rd_acc   = i_rinc & ~o_rempty & ~i_flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CW'(1);
      end
    end
    ovf_d = (ovf_q & ~i_clr_err) | (i_winc & o_wfull & ~i_flush);
    unf_d = (unf_q & ~i_clr_err) | (i_rinc & o_rempty & ~i_flush);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_wdata;
  end

`ifdef SFIFO_PROG_FWFT_EN
  assign o_rdata  = mem_q[rd_ptr_q];
  assign o_rvalid = ~o_rempty;
`else
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
`endif

endmodule
